// File: rtl/fpmu_mac_pkg.sv
// Shared types and sizing helpers for the FPMU multiply-accumulate sequencer.
package fpmu_mac_pkg;

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} mac_state_t;

  // Headroom for N_INPUTS products plus the bias, plus a guard bit.
  function automatic int acc_width(input int width, input int n_inputs);
    return width + $clog2(n_inputs + 1) + 1;
  endfunction

endpackage

// File: rtl/fp_sat_clamp.sv
// Combinational saturating narrower: clamps a wide value to OUT_W bits and flags clamping.
module fp_sat_clamp #(
  parameter int SIGN  = 1,
  parameter int IN_W  = 12,
  parameter int OUT_W = 8
) (
  input  logic [IN_W-1:0]  din,
  output logic [OUT_W-1:0] dout,
  output logic             sat
);

  // Returns {sat, value}.
  function automatic logic [OUT_W:0] clamp(input logic [IN_W-1:0] x);
    logic [OUT_W:0] r;
    r = {1'b0, x[OUT_W-1:0]};
    if (SIGN != 0) begin
      if (x[IN_W-1:OUT_W-1] != '0 && x[IN_W-1:OUT_W-1] != '1)
        r = x[IN_W-1] ? {2'b11, {(OUT_W-1){1'b0}}} : {2'b10, {(OUT_W-1){1'b1}}};
    end else if (x[IN_W-1:OUT_W] != '0) begin
      r = {1'b1, {OUT_W{1'b1}}};
    end
    return r;
  endfunction

  assign {sat, dout} = clamp(din);

endmodule

// File: rtl/fpmu.sv
// Combinational fixed-point multiplier: truncates fractional LSBs, wraps the integer MSBs.
module fpmu #(
  parameter int SIGN         = 1,
  parameter int WIDTH        = 8,
  parameter int FP_POSITIONS = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result
);

  logic [2*WIDTH-1:0] a_x;
  logic [2*WIDTH-1:0] b_x;
  logic [2*WIDTH-1:0] prod;

  // Low 2*WIDTH bits of the extended product are exact for both signed and unsigned.
  assign a_x    = {{WIDTH{(SIGN != 0) && a[WIDTH-1]}}, a};
  assign b_x    = {{WIDTH{(SIGN != 0) && b[WIDTH-1]}}, b};
  assign prod   = a_x * b_x;
  assign result = WIDTH'(prod >> FP_POSITIONS);

endmodule

// File: rtl/fpmu_mac_sequencer.sv
// Neuron dot product: out = sat(bias + sum a[i]*b[i]) through one shared FPMU.
module fpmu_mac_sequencer
  import fpmu_mac_pkg::*;
#(
  parameter int SIGN         = 1,
  parameter int WIDTH        = 8,
  parameter int FP_POSITIONS = 4,
  parameter int N_INPUTS     = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] bias,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_sat,
  output logic             busy
);

  localparam int ACC_W = acc_width(WIDTH, N_INPUTS);
  localparam int CNT_W = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_INPUTS - 1);

  mac_state_t              state;
  logic [CNT_W-1:0]        count;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_next;
  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] bias_ext;
  logic [WIDTH-1:0]        prod;
  logic [WIDTH-1:0]        clamp_data;
  logic                    clamp_sat;

  fpmu #(
    .SIGN        (SIGN),
    .WIDTH       (WIDTH),
    .FP_POSITIONS(FP_POSITIONS)
  ) u_fpmu (
    .a     (in_a),
    .b     (in_b),
    .result(prod)
  );

  assign prod_ext = {{(ACC_W-WIDTH){(SIGN != 0) && prod[WIDTH-1]}}, prod};
  assign bias_ext = {{(ACC_W-WIDTH){(SIGN != 0) && bias[WIDTH-1]}}, bias};
  assign acc_next = acc + prod_ext;

  // Clamp the post-add sum so the final beat's result registers with the DONE transition.
  fp_sat_clamp #(
    .SIGN (SIGN),
    .IN_W (ACC_W),
    .OUT_W(WIDTH)
  ) u_clamp (
    .din (acc_next),
    .dout(clamp_data),
    .sat (clamp_sat)
  );

  assign start_ready = (state == IDLE);
  assign in_ready    = (state == ACCUM);
  assign busy        = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      count     <= '0;
      acc       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_valid) begin
            acc   <= bias_ext;
            count <= '0;
            state <= ACCUM;
          end
        end
        ACCUM: begin
          if (in_valid) begin
            acc <= acc_next;
            if (count == LAST) begin
              count     <= '0;
              state     <= DONE;
              out_valid <= 1'b1;
              out_data  <= clamp_data;
              out_sat   <= clamp_sat;
            end else begin
              count <= count + 1'b1;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpmu_mac_sequencer.sv
// Scoreboard bench for fpmu_mac_sequencer at default parameters (Q4.4 signed, 4 inputs).
module tb_fpmu_mac_sequencer;

  typedef logic [7:0] vec_t [4];

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_valid = 1'b0;
  logic       start_ready;
  logic [7:0] bias = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_a = 8'h00;
  logic [7:0] in_b = 8'h00;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] out_data;
  logic       out_sat;
  logic       busy;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [8:0] exp_q [$];
  vec_t       va, vb;

  always #5 clk = ~clk;

  fpmu_mac_sequencer #(
    .SIGN(1), .WIDTH(8), .FP_POSITIONS(4), .N_INPUTS(4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_valid(start_valid),
    .start_ready(start_ready),
    .bias       (bias),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_sat    (out_sat),
    .busy       (busy)
  );

  // Reference: Q4.4 product floored and wrapped to 8 bits, summed wide, then clamped.
  function automatic logic [8:0] model(input logic [7:0] bs, input vec_t a, input vec_t b);
    int sum, pr;
    sum = int'($signed(bs));
    for (int i = 0; i < 4; i++) begin
      pr = int'($signed(a[i])) * int'($signed(b[i]));
      pr = pr >>> 4;
      pr = pr & 255;
      if (pr > 127) pr = pr - 256;
      sum = sum + pr;
    end
    if (sum > 127) return {1'b1, 8'h7F};
    if (sum < -128) return {1'b1, 8'h80};
    return {1'b0, 8'(sum)};
  endfunction

  task automatic do_start(input logic [7:0] bv, input string name);
    logic rdy, ok;
    ok = 1'b0;
    bias = bv;
    start_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      rdy = start_ready;
      @(posedge clk); #1;
      if (rdy) begin ok = 1'b1; break; end
    end
    start_valid = 1'b0;
    n_cmp++;
    if (ok !== 1'b1) begin
      n_bad++;
      $display("FAIL %s_start: accepted=%0b required=1", name, ok);
    end
  endtask

  task automatic feed(input int first, input int last, input int gap, input string name,
                      output int edges);
    logic rdy, ok;
    edges = 0;
    for (int i = first; i <= last; i++) begin
      in_valid = 1'b0;
      repeat (gap) begin
        in_a = 8'($urandom);
        in_b = 8'($urandom);
        @(posedge clk); #1;
        edges++;
      end
      in_valid = 1'b1;
      in_a = va[i];
      in_b = vb[i];
      ok = 1'b0;
      for (int k = 0; k < 20; k++) begin
        rdy = in_ready;
        @(posedge clk); #1;
        edges++;
        if (rdy) begin ok = 1'b1; break; end
      end
      n_cmp++;
      if (ok !== 1'b1) begin
        n_bad++;
        $display("FAIL %s_beat%0d: accepted=%0b required=1", name, i, ok);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic collect(input int stall, input string name);
    logic       ok;
    logic [7:0] snap;
    logic [8:0] e;
    ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (out_valid === 1'b1) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    n_cmp++;
    if (ok !== 1'b1) begin
      n_bad++;
      $display("FAIL %s_timeout: out_valid=%b required=1", name, out_valid);
    end else begin
      snap = out_data;
      for (int s = 0; s < stall; s++) begin
        n_cmp++;
        if ({out_valid, out_data, in_ready, start_ready} !== {1'b1, snap, 1'b0, 1'b0}) begin
          n_bad++;
          $display("FAIL %s_stall%0d: valid=%b data=%h in_rdy=%b st_rdy=%b required 1 %h 0 0",
                   name, s, out_valid, out_data, in_ready, start_ready, snap);
        end
        @(posedge clk); #1;
      end
      out_ready = 1'b1;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL %s_result: got sat=%b data=%h with no expected entry", name, out_sat, out_data);
      end else begin
        e = exp_q.pop_front();
        if ({out_sat, out_data} !== e) begin
          n_bad++;
          $display("FAIL %s_result: sat=%b data=%h required sat=%b data=%h",
                   name, out_sat, out_data, e[8], e[7:0]);
        end
      end
      @(posedge clk); #1;
      n_cmp++;
      if ({out_valid, busy, start_ready} !== 3'b001) begin
        n_bad++;
        $display("FAIL %s_release: valid=%b busy=%b st_rdy=%b required 0 0 1",
                 name, out_valid, busy, start_ready);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    n_cmp++;
    if ({out_valid, out_data, out_sat, busy, start_ready, in_ready} !== {1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0}) begin
      n_bad++;
      $display("FAIL reset: valid=%b data=%h sat=%b busy=%b st_rdy=%b in_rdy=%b required 0 00 0 0 1 0",
               out_valid, out_data, out_sat, busy, start_ready, in_ready);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int edges;
    va = '{8'h10, 8'h10, 8'h20, 8'h00};
    vb = '{8'h10, 8'hF0, 8'h08, 8'h55};
    exp_q.push_back({1'b0, 8'h18});
    do_start(8'h08, "basic");
    feed(0, 3, 0, "basic", edges);
    n_cmp++;
    if (edges !== 4 || out_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL basic_latency: beat_edges=%0d valid=%b required 4 1", edges, out_valid);
    end
    collect(0, "basic");
  endtask

  task automatic test_pos_sat();
    int edges;
    va = '{8'h20, 8'h20, 8'h20, 8'h20};
    vb = '{8'h18, 8'h18, 8'h18, 8'h18};
    exp_q.push_back({1'b1, 8'h7F});
    do_start(8'h00, "pos_sat");
    feed(0, 3, 0, "pos_sat", edges);
    collect(0, "pos_sat");
  endtask

  task automatic test_neg_sat();
    int edges;
    va = '{8'hF0, 8'hF0, 8'hF0, 8'hF0};
    vb = '{8'h10, 8'h10, 8'h10, 8'h10};
    exp_q.push_back({1'b1, 8'h80});
    do_start(8'h80, "neg_sat");
    feed(0, 3, 0, "neg_sat", edges);
    collect(0, "neg_sat");
  endtask

  task automatic test_gaps_backpressure();
    int edges;
    va = '{8'h10, 8'h10, 8'h20, 8'h00};
    vb = '{8'h10, 8'hF0, 8'h08, 8'h55};
    exp_q.push_back({1'b0, 8'h18});
    out_ready = 1'b0;
    do_start(8'h08, "gaps");
    feed(0, 3, 2, "gaps", edges);
    collect(3, "gaps");
  endtask

  task automatic test_start_in_done();
    int         edges;
    logic [8:0] e;
    va = '{8'h10, 8'h10, 8'h20, 8'h00};
    vb = '{8'h10, 8'hF0, 8'h08, 8'h55};
    exp_q.push_back({1'b0, 8'h18});
    exp_q.push_back({1'b0, 8'h50});
    do_start(8'h08, "sid");
    feed(0, 1, 0, "sid", edges);
    bias = 8'h40;
    start_valid = 1'b1;
    out_ready = 1'b0;
    feed(2, 3, 0, "sid", edges);
    repeat (2) begin
      @(posedge clk); #1;
      n_cmp++;
      if ({busy, out_valid, start_ready} !== 3'b110) begin
        n_bad++;
        $display("FAIL sid_hold: busy=%b valid=%b st_rdy=%b required 1 1 0", busy, out_valid, start_ready);
      end
    end
    out_ready = 1'b1;
    e = exp_q.pop_front();
    n_cmp++;
    if ({out_sat, out_data} !== e) begin
      n_bad++;
      $display("FAIL sid_result1: sat=%b data=%h required sat=%b data=%h", out_sat, out_data, e[8], e[7:0]);
    end
    @(posedge clk); #1;
    n_cmp++;
    if ({out_valid, busy, start_ready} !== 3'b001) begin
      n_bad++;
      $display("FAIL sid_after_hs: valid=%b busy=%b st_rdy=%b required 0 0 1", out_valid, busy, start_ready);
    end
    @(posedge clk); #1;
    start_valid = 1'b0;
    bias = 8'h99;
    n_cmp++;
    if ({busy, start_ready, in_ready} !== 3'b101) begin
      n_bad++;
      $display("FAIL sid_start2: busy=%b st_rdy=%b in_rdy=%b required 1 0 1", busy, start_ready, in_ready);
    end
    feed(0, 3, 0, "sid2", edges);
    collect(0, "sid2");
  endtask

  task automatic test_reset_mid_job();
    int edges;
    va = '{8'h20, 8'h20, 8'h20, 8'h20};
    vb = '{8'h18, 8'h18, 8'h18, 8'h18};
    do_start(8'h30, "rmj");
    feed(0, 1, 0, "rmj", edges);
    rst_n = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if ({out_valid, busy, start_ready, in_ready} !== 4'b0010) begin
      n_bad++;
      $display("FAIL rmj_reset: valid=%b busy=%b st_rdy=%b in_rdy=%b required 0 0 1 0",
               out_valid, busy, start_ready, in_ready);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL rmj_no_partial: valid=%b required 0", out_valid);
    end
    va = '{8'h10, 8'h10, 8'h20, 8'h00};
    vb = '{8'h10, 8'hF0, 8'h08, 8'h55};
    exp_q.push_back({1'b0, 8'h18});
    do_start(8'h08, "rmj_fresh");
    feed(0, 3, 0, "rmj_fresh", edges);
    collect(0, "rmj_fresh");
  endtask

  task automatic test_back_to_back();
    int         edges;
    logic [7:0] bs;
    for (int j = 0; j < 6; j++) begin
      for (int i = 0; i < 4; i++) begin
        va[i] = 8'($urandom);
        vb[i] = 8'($urandom_range(0, 63));
      end
      bs = 8'($urandom);
      exp_q.push_back(model(bs, va, vb));
      do_start(bs, "b2b");
      feed(0, 3, j % 2, "b2b", edges);
      collect(0, "b2b");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_pos_sat();
    test_neg_sat();
    test_gaps_backpressure();
    test_start_in_done();
    test_reset_mid_job();
    test_back_to_back();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL leftover: pending=%0d required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
